vector_mem_wb_stage: RTL and testbench
======================================

// Module: vector_mem_wb_stage
// PURPOSE
// - Memory + writeback stage fed by the vector execute datapath: accepts the execute-stage result,
//   store data and control, performs 48-bit vector loads/stores as LANES serial byte transfers over
//   an 8-bit req/ack memory port, and returns resultW/WA3W/regWriteW/PCSrcW to the register file/PC.
// - Drives stallM back to fetch/decode/execute while a vector transfer is in progress.
// PARAMETERS
// - LANES    6   byte lanes per vector (vector width = LANES*LANE_W)
// - LANE_W   8   bits per lane = memory data width
// - ADDR_W   16  memory address width; base address = postAluResult[ADDR_W-1:0]
// - TIMEOUT  64  max cycles memReq may wait for memAck (used only with VMEM_TIMEOUT_EN)
// PORTS
// - clk            in   1   clock, all state on rising edge
// - rst            in   1   asynchronous, active-high reset
// - regWriteE      in   1   execute: register write enable
// - memToRegE      in   1   execute: load (result comes from memory)
// - memWriteE      in   1   execute: store
// - PCSrcE         in   1   execute: result is a new PC
// - WA3E           in   4   execute: destination register
// - postAluResult  in   48  execute: ALU/immediate result; low ADDR_W bits = base address for mem ops
// - srcB           in   48  execute: store data, lane i = srcB[8i+7:8i]
// - memAddr        out  16  byte address of current lane = base + lane count, wraps mod 2^16
// - memWData       out  8   store byte of current lane
// - memWe          out  1   1 = write transfer, 0 = read
// - memReq         out  1   transfer request, held until memAck
// - memRData       in   8   load byte, valid when memAck=1
// - memAck         in   1   transfer complete this cycle (same-cycle ack allowed)
// - stallM         out  1   freeze upstream pipeline and hold execute inputs
// - resultW        out  48  writeback data
// - WA3W           out  4   writeback destination register
// - regWriteW      out  1   writeback register write enable (one-cycle pulse per instruction)
// - PCSrcW         out  1   writeback PC redirect
// - memErr         out  1   sticky timeout error (VMEM_TIMEOUT_EN only, else tied 0)
// BEHAVIOUR
// - Reset: M and W registers cleared, state IDLE, lane count 0; all outputs 0 (memReq drops immediately).
// - M register captures execute inputs on every edge where stallM=0; W register captures M result.
// - Latency: non-memory op on execute inputs at edge k -> W outputs valid after edge k+1, for 1 cycle.
// - memWriteE=1 -> store (memToRegE ignored); else memToRegE=1 -> load; else pass-through.
// - FSM IDLE -> XFER when M holds a mem op; XFER: memReq=1, memAddr=base+cnt, memWe=store,
//   memWData=srcB lane cnt; on memAck: load captures memRData into lane cnt, cnt++.
// - Ack on lane LANES-1: W captures (load: assembled vector; store: postAluResult), cnt->0, FSM->IDLE,
//   M accepts next op the same edge; back-to-back mem ops start without an idle cycle.
// - stallM = M holds mem op AND NOT (memAck AND cnt==LANES-1); combinational.
// - While stalled W shows a bubble: regWriteW=0, PCSrcW=0 (no duplicate register write).
// - Store: regWriteW = M regWrite as decoded; PCSrcW passes through on all op types.
// - Address wrap: 0xFFFF + 1 -> 0x0000, no error.
// - Reset mid-transfer aborts: no partial writeback, next op begins at lane 0.
// CONFIGURATION
// - VMEM_TIMEOUT_EN defined: counter of cycles with memReq=1 and memAck=0, cleared on ack; at TIMEOUT
//   the op aborts: memReq=0, W bubble (regWriteW=0), memErr set sticky until rst, stall released.
// - VMEM_TIMEOUT_EN undefined: no counter, waits for memAck forever, memErr tied 0.
// TESTING
// - Pass-through: postAluResult=48'h060504030201, regWriteE=1, WA3E=3 -> two edges later resultW same,
//   WA3W=3, regWriteW=1 for exactly 1 cycle, stallM=0 throughout.
// - Store, memAck tied 1: base 0x0010, srcB=48'hAABBCCDDEEFF -> memAddr 0x10..0x15, memWData
//   FF,EE,DD,CC,BB,AA, memWe=1, memReq high 6 cycles, stallM high first 5 cycles.
// - Load, ack every 2nd cycle, base 0xFFFE, memory bytes 11..66 -> addrs FFFE,FFFF,0000..0003,
//   resultW=48'h665544332211, regWriteW single pulse, stallM high until last ack cycle.
// - ALU op queued behind a load: held in execute while stallM=1, writes back the cycle after the load.
// - rst asserted after lane 2 of a load -> memReq/regWriteW 0 at once; subsequent store starts at lane 0.
// - VMEM_TIMEOUT_EN, memAck stuck 0 -> after 64 cycles memReq=0, memErr=1, stallM=0, no reg write.

Source files
------------

// File: rtl/vector_mem_wb_stage.sv
// Vector memory + writeback stage: 48-bit loads/stores as LANES serial byte transfers on a req/ack port.
// Optional VMEM_TIMEOUT_EN: aborts a transfer left unacknowledged for TIMEOUT cycles and sets memErr.
module vector_mem_wb_stage #(
  parameter int unsigned LANES   = 6,
  parameter int unsigned LANE_W  = 8,
  parameter int unsigned ADDR_W  = 16,
  parameter int unsigned TIMEOUT = 64
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      regWriteE,
  input  logic                      memToRegE,
  input  logic                      memWriteE,
  input  logic                      PCSrcE,
  input  logic [3:0]                WA3E,
  input  logic [LANES*LANE_W-1:0]   postAluResult,
  input  logic [LANES*LANE_W-1:0]   srcB,
  output logic [ADDR_W-1:0]         memAddr,
  output logic [LANE_W-1:0]         memWData,
  output logic                      memWe,
  output logic                      memReq,
  input  logic [LANE_W-1:0]         memRData,
  input  logic                      memAck,
  output logic                      stallM,
  output logic [LANES*LANE_W-1:0]   resultW,
  output logic [3:0]                WA3W,
  output logic                      regWriteW,
  output logic                      PCSrcW,
  output logic                      memErr
);

  localparam int unsigned VEC_W = LANES * LANE_W;
  localparam int unsigned CNT_W = $clog2(LANES);
  localparam logic [CNT_W-1:0] LAST_LANE = CNT_W'(LANES - 1);

  if (LANES < 2 || TIMEOUT < 1) begin : g_param_chk
    $error("vector_mem_wb_stage: LANES must be >= 2 and TIMEOUT >= 1");
  end

  typedef enum logic {IDLE, XFER} state_e;
  state_e state_q, state_d;

  logic                          regWriteM_q, memToRegM_q, memWriteM_q, PCSrcM_q;
  logic [3:0]                    WA3M_q;
  logic [VEC_W-1:0]              aluM_q;
  logic [LANES-1:0][LANE_W-1:0]  srcBM_q;

  logic [CNT_W-1:0]              cnt_q, cnt_d;
  logic [LANES-1:0][LANE_W-1:0]  ldBuf_q, ldVec;

  logic [VEC_W-1:0]              resultW_q;
  logic [3:0]                    WA3W_q;
  logic                          regWriteW_q, PCSrcW_q;

  logic lastAck, abort, doneM, accept, wValid;
  logic [VEC_W-1:0] wResult;

`ifdef VMEM_TIMEOUT_EN
  localparam int unsigned TO_W = $clog2(TIMEOUT + 1);
  logic [TO_W-1:0] toCnt_q, toCnt_d;
  logic            memErr_q, memErr_d;

  assign abort = (state_q == XFER) && !memAck && (toCnt_q == TO_W'(TIMEOUT - 1));

  always_comb begin
    toCnt_d  = '0;
    if (state_q == XFER && !memAck && !abort) toCnt_d = toCnt_q + 1'b1;
    memErr_d = memErr_q | abort;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      toCnt_q  <= '0;
      memErr_q <= 1'b0;
    end else begin
      toCnt_q  <= toCnt_d;
      memErr_q <= memErr_d;
    end
  end

  assign memErr = memErr_q;
`else
  assign abort  = 1'b0;
  assign memErr = 1'b0;
`endif

  // XFER is exactly "M holds a mem op", so the FSM follows M capture and back-to-back ops need no idle gap.
  assign lastAck = (state_q == XFER) && memAck && (cnt_q == LAST_LANE);
  assign doneM   = lastAck || abort;
  assign accept  = (state_q == IDLE) || doneM;
  assign wValid  = accept && !abort;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (accept) state_d = (memWriteE || memToRegE) ? XFER : IDLE;
  end

  always_comb begin
    memReq   = 1'b0;
    memWe    = 1'b0;
    stallM   = 1'b0;
    memAddr  = aluM_q[ADDR_W-1:0] + ADDR_W'(cnt_q);
    memWData = srcBM_q[cnt_q];
    if (state_q == XFER) begin
      memReq = 1'b1;
      memWe  = memWriteM_q;
      stallM = !doneM;
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    if (doneM)                           cnt_d = '0;
    else if (state_q == XFER && memAck)  cnt_d = cnt_q + 1'b1;
  end

  // The lane arriving this cycle is merged in so the final ack can write back without an extra cycle.
  always_comb begin
    ldVec        = ldBuf_q;
    ldVec[cnt_q] = memRData;
    wResult      = (memToRegM_q && !memWriteM_q) ? ldVec : aluM_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      regWriteM_q <= 1'b0;
      memToRegM_q <= 1'b0;
      memWriteM_q <= 1'b0;
      PCSrcM_q    <= 1'b0;
      WA3M_q      <= '0;
      aluM_q      <= '0;
      srcBM_q     <= '0;
      cnt_q       <= '0;
      ldBuf_q     <= '0;
      resultW_q   <= '0;
      WA3W_q      <= '0;
      regWriteW_q <= 1'b0;
      PCSrcW_q    <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      if (state_q == XFER && memAck) ldBuf_q <= ldVec;
      if (accept) begin
        regWriteM_q <= regWriteE;
        memToRegM_q <= memToRegE;
        memWriteM_q <= memWriteE;
        PCSrcM_q    <= PCSrcE;
        WA3M_q      <= WA3E;
        aluM_q      <= postAluResult;
        srcBM_q     <= srcB;
      end
      if (wValid) begin
        resultW_q   <= wResult;
        WA3W_q      <= WA3M_q;
        regWriteW_q <= regWriteM_q;
        PCSrcW_q    <= PCSrcM_q;
      end else begin
        regWriteW_q <= 1'b0;
        PCSrcW_q    <= 1'b0;
      end
    end
  end

  assign resultW   = resultW_q;
  assign WA3W      = WA3W_q;
  assign regWriteW = regWriteW_q;
  assign PCSrcW    = PCSrcW_q;

endmodule

// File: tb/tb_vector_mem_wb_stage.sv
// Self-checking bench for vector_mem_wb_stage: directed vectors/sequences plus a randomized run
// against a transaction-level reference model (byte memory image + expected transfer/writeback queues).
module tb_vector_mem_wb_stage;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        regWriteE = 1'b0, memToRegE = 1'b0, memWriteE = 1'b0, PCSrcE = 1'b0;
  logic [3:0]  WA3E = '0;
  logic [47:0] postAluResult = '0, srcB = '0;
  logic [15:0] memAddr;
  logic [7:0]  memWData;
  logic        memWe, memReq;
  logic [7:0]  memRData = '0;
  logic        memAck = 1'b0;
  logic        stallM;
  logic [47:0] resultW;
  logic [3:0]  WA3W;
  logic        regWriteW, PCSrcW, memErr;

  vector_mem_wb_stage #(.LANES(6), .LANE_W(8), .ADDR_W(16), .TIMEOUT(64)) dut (
    .clk(clk), .rst(rst),
    .regWriteE(regWriteE), .memToRegE(memToRegE), .memWriteE(memWriteE), .PCSrcE(PCSrcE),
    .WA3E(WA3E), .postAluResult(postAluResult), .srcB(srcB),
    .memAddr(memAddr), .memWData(memWData), .memWe(memWe), .memReq(memReq),
    .memRData(memRData), .memAck(memAck), .stallM(stallM),
    .resultW(resultW), .WA3W(WA3W), .regWriteW(regWriteW), .PCSrcW(PCSrcW), .memErr(memErr)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: actual=%h required=%h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Memory seen by the DUT and the reference image of what memory should hold.
  logic [7:0] phys_mem [65536];
  logic [7:0] ref_mem  [65536];

  function automatic logic [7:0] pat(input int unsigned a);
    return 8'(a * 7 + (a >> 8) * 13 + 32'h3C);
  endfunction

  task automatic init_mem();
    for (int unsigned a = 0; a < 65536; a++) begin
      phys_mem[a] = pat(a);
      ref_mem[a]  = pat(a);
    end
  endtask

  typedef struct { logic [15:0] addr; logic we; logic [7:0] data; } xfer_t;
  typedef struct { logic [47:0] res; logic [3:0] wa3; logic rw; logic pc; } wb_t;
  xfer_t xq[$];
  wb_t   wq[$];

  int ack_mode = 1;   // 0 never, 1 always, 2 every 2nd cycle, 3 random
  bit ack_ph   = 1'b0;
  bit mon_en   = 1'b0;

  // Memory responder: decides ack at negedge, performs the transfer, checks it against the model.
  always @(negedge clk) begin
    xfer_t x;
    if (memReq) begin
      case (ack_mode)
        0:       memAck = 1'b0;
        1:       memAck = 1'b1;
        2:       begin memAck = ack_ph; ack_ph = ~ack_ph; end
        default: memAck = ($urandom_range(0, 2) == 0);
      endcase
    end else begin
      memAck = 1'b0;
      ack_ph = 1'b0;
    end
    memRData = (memAck && !memWe) ? phys_mem[memAddr] : 8'h00;
    if (memReq && memAck) begin
      if (memWe) phys_mem[memAddr] = memWData;
      if (mon_en) begin
        chk("xfer_expected", 64'(xq.size() != 0), 64'd1);
        if (xq.size() != 0) begin
          x = xq.pop_front();
          chk("xfer_addr", 64'(memAddr), 64'(x.addr));
          chk("xfer_we", 64'(memWe), 64'(x.we));
          if (x.we) chk("xfer_wdata", 64'(memWData), 64'(x.data));
        end
      end
    end
  end

  always @(posedge clk) begin
    wb_t w;
    #1;
    if (mon_en && (regWriteW || PCSrcW)) begin
      chk("wb_expected", 64'(wq.size() != 0), 64'd1);
      if (wq.size() != 0) begin
        w = wq.pop_front();
        chk("wb_result", 64'(resultW), 64'(w.res));
        chk("wb_wa3", 64'(WA3W), 64'(w.wa3));
        chk("wb_regwrite", 64'(regWriteW), 64'(w.rw));
        chk("wb_pcsrc", 64'(PCSrcW), 64'(w.pc));
      end
    end
  end

  initial begin
    #600000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic rw, input logic mr, input logic mw, input logic pc,
                       input logic [3:0] wa, input logic [47:0] alu, input logic [47:0] sb);
    regWriteE = rw; memToRegE = mr; memWriteE = mw; PCSrcE = pc;
    WA3E = wa; postAluResult = alu; srcB = sb;
  endtask

  task automatic clear_in();
    drive(1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 48'd0, 48'd0);
  endtask

  // Reference model: enqueue the transfers and writeback a single instruction must produce.
  task automatic model_issue(input logic rw, input logic mr, input logic mw, input logic pc,
                             input logic [3:0] wa, input logic [47:0] alu, input logic [47:0] sb);
    wb_t         w;
    xfer_t       x;
    logic [15:0] base;
    logic [15:0] a;
    base  = alu[15:0];
    w.res = alu;
    for (int unsigned i = 0; i < 6; i++) begin
      a = 16'(base + i);
      if (mw) begin
        x.addr = a; x.we = 1'b1; x.data = sb[i*8 +: 8];
        xq.push_back(x);
        ref_mem[a] = sb[i*8 +: 8];
      end else if (mr) begin
        x.addr = a; x.we = 1'b0; x.data = 8'h00;
        xq.push_back(x);
        w.res[i*8 +: 8] = ref_mem[a];
      end
    end
    w.wa3 = wa; w.rw = rw; w.pc = pc;
    if (rw || pc) wq.push_back(w);
  endtask

  typedef struct {
    logic rw; logic pc; logic [3:0] wa3; logic [47:0] alu;
    logic [47:0] e_res; logic [3:0] e_wa3; logic e_rw; logic e_pc;
  } vec_t;

  initial begin
    vec_t        tbl[4];
    logic [15:0] addr_log[$];
    logic [51:0] wbl[$];
    int          wbc[$];
    int          stall_cnt, wr_seen, req_cnt;
    bit          alu_pend, go, acc;
    logic        r_rw, r_mr, r_mw, r_pc;
    logic [3:0]  r_wa;
    logic [47:0] r_alu, r_sb;
    int          kind;

    init_mem();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_memReq", 64'(memReq), 0);
    chk("rst_stallM", 64'(stallM), 0);
    chk("rst_regWriteW", 64'(regWriteW), 0);
    chk("rst_PCSrcW", 64'(PCSrcW), 0);
    chk("rst_resultW", 64'(resultW), 0);
    chk("rst_WA3W", 64'(WA3W), 0);
    chk("rst_memAddr", 64'(memAddr), 0);
    chk("rst_memWe", 64'(memWe), 0);
    chk("rst_memErr", 64'(memErr), 0);
    rst = 1'b0;
    tick();

    // Pass-through vectors: writeback one edge after M capture, for exactly one cycle.
    tbl[0] = '{1'b1, 1'b0, 4'd3,  48'h060504030201, 48'h060504030201, 4'd3,  1'b1, 1'b0};
    tbl[1] = '{1'b0, 1'b1, 4'd0,  48'h000000001234, 48'h000000001234, 4'd0,  1'b0, 1'b1};
    tbl[2] = '{1'b1, 1'b1, 4'd15, 48'hFFFFFFFFFFFF, 48'hFFFFFFFFFFFF, 4'd15, 1'b1, 1'b1};
    tbl[3] = '{1'b0, 1'b0, 4'd7,  48'h000000000ABC, 48'h000000000ABC, 4'd7,  1'b0, 1'b0};
    ack_mode = 1;
    for (int i = 0; i < 4; i++) begin
      drive(tbl[i].rw, 1'b0, 1'b0, tbl[i].pc, tbl[i].wa3, tbl[i].alu, 48'h0);
      tick();
      clear_in();
      chk("pt_stallM", 64'(stallM), 0);
      tick();
      chk("pt_resultW", 64'(resultW), 64'(tbl[i].e_res));
      chk("pt_WA3W", 64'(WA3W), 64'(tbl[i].e_wa3));
      chk("pt_regWriteW", 64'(regWriteW), 64'(tbl[i].e_rw));
      chk("pt_PCSrcW", 64'(PCSrcW), 64'(tbl[i].e_pc));
      tick();
      chk("pt_pulse_rw", 64'(regWriteW), 0);
      chk("pt_pulse_pc", 64'(PCSrcW), 0);
    end

    // Store with memAck tied high.
    drive(1'b0, 1'b0, 1'b1, 1'b0, 4'd2, 48'h000000000010, 48'hAABBCCDDEEFF);
    tick();
    clear_in();
    for (int i = 0; i < 6; i++) begin
      chk("st_memReq", 64'(memReq), 1);
      chk("st_memAddr", 64'(memAddr), 64'(16'h0010 + i));
      chk("st_memWData", 64'(memWData), 64'(8'hFF - 8'(i * 8'h11)));
      chk("st_memWe", 64'(memWe), 1);
      @(negedge clk);
      #1;
      chk("st_stallM", 64'(stallM), 64'(i < 5));
      tick();
    end
    chk("st_memReq_done", 64'(memReq), 0);
    chk("st_regWriteW", 64'(regWriteW), 0);
    chk("st_mem_lo", 64'(phys_mem[16'h0010]), 64'h FF);
    chk("st_mem_hi", 64'(phys_mem[16'h0015]), 64'h AA);

    // Load across the address wrap, ack every 2nd cycle, with an ALU op queued behind it.
    phys_mem[16'hFFFE] = 8'h11; phys_mem[16'hFFFF] = 8'h22;
    phys_mem[16'h0000] = 8'h33; phys_mem[16'h0001] = 8'h44;
    phys_mem[16'h0002] = 8'h55; phys_mem[16'h0003] = 8'h66;
    ack_mode = 2;
    drive(1'b1, 1'b1, 1'b0, 1'b0, 4'd5, 48'h00000000FFFE, 48'h0);
    tick();
    drive(1'b1, 1'b0, 1'b0, 1'b0, 4'd9, 48'h123456789ABC, 48'h0);
    alu_pend  = 1'b1;
    stall_cnt = 0;
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      #1;
      if (memReq && memAck) addr_log.push_back(memAddr);
      if (stallM) stall_cnt++;
      go = alu_pend && !stallM;
      tick();
      if (go) begin clear_in(); alu_pend = 1'b0; end
      if (regWriteW) begin wbl.push_back({WA3W, resultW}); wbc.push_back(c); end
    end
    chk("ld_stall_cycles", 64'(stall_cnt), 11);
    chk("ld_xfer_count", 64'(addr_log.size()), 6);
    if (addr_log.size() == 6)
      for (int i = 0; i < 6; i++) chk("ld_addr", 64'(addr_log[i]), 64'(16'(16'hFFFE + i)));
    chk("ld_wb_count", 64'(wbl.size()), 2);
    if (wbl.size() == 2) begin
      chk("ld_result", 64'(wbl[0]), 64'({4'd5, 48'h665544332211}));
      chk("ld_alu_after", 64'(wbl[1]), 64'({4'd9, 48'h123456789ABC}));
      chk("ld_alu_next_cycle", 64'(wbc[1] - wbc[0]), 1);
    end

    // Reset in the middle of a load, then a store must start from lane 0.
    ack_mode = 1;
    drive(1'b1, 1'b1, 1'b0, 1'b0, 4'd4, 48'h000000000100, 48'h0);
    tick();
    clear_in();
    tick(); tick(); tick();
    chk("mid_addr_lane3", 64'(memAddr), 64'h0103);
    chk("mid_no_wb", 64'(regWriteW), 0);
    rst = 1'b1;
    #1;
    chk("mid_rst_memReq", 64'(memReq), 0);
    chk("mid_rst_regWriteW", 64'(regWriteW), 0);
    chk("mid_rst_stallM", 64'(stallM), 0);
    tick();
    rst = 1'b0;
    drive(1'b0, 1'b0, 1'b1, 1'b0, 4'd1, 48'h000000000200, 48'h0102030405A5);
    tick();
    clear_in();
    chk("post_rst_addr", 64'(memAddr), 64'h0200);
    chk("post_rst_wdata", 64'(memWData), 64'hA5);
    wr_seen = 0;
    for (int c = 0; c < 20; c++) begin
      tick();
      if (regWriteW) wr_seen++;
      if (!memReq) break;
    end
    chk("post_rst_done", 64'(memReq), 0);
    chk("post_rst_no_wb", 64'(wr_seen), 0);

`ifdef VMEM_TIMEOUT_EN
    // memAck stuck low: the op must give up after TIMEOUT cycles of request.
    ack_mode = 0;
    drive(1'b1, 1'b1, 1'b0, 1'b0, 4'd6, 48'h000000000300, 48'h0);
    tick();
    clear_in();
    req_cnt = 0;
    wr_seen = 0;
    while (memReq && req_cnt < 100) begin
      req_cnt++;
      tick();
      if (regWriteW) wr_seen++;
    end
    chk("to_req_cycles", 64'(req_cnt), 64);
    chk("to_memErr", 64'(memErr), 1);
    chk("to_stallM", 64'(stallM), 0);
    chk("to_no_wb", 64'(wr_seen), 0);
    tick();
    chk("to_memErr_sticky", 64'(memErr), 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("to_memErr_cleared", 64'(memErr), 0);
`else
    req_cnt = 0;
`endif

    // Randomized instruction stream against the reference model.
    init_mem();
    xq.delete();
    wq.delete();
    ack_mode = 3;
    mon_en   = 1'b1;
    for (int n = 0; n < 60; n++) begin
      kind  = int'($urandom_range(0, 2));
      r_rw  = 1'($urandom());
      r_pc  = ($urandom_range(0, 4) == 0);
      r_wa  = 4'($urandom());
      r_alu = 48'({$urandom(), $urandom()});
      r_sb  = 48'({$urandom(), $urandom()});
      if ($urandom_range(0, 3) == 0) r_alu[15:0] = 16'hFFFA + 16'($urandom_range(0, 5));
      r_mw  = (kind == 2);
      r_mr  = (kind == 1) || (kind == 2 && 1'($urandom()));
      model_issue(r_rw, r_mr, r_mw, r_pc, r_wa, r_alu, r_sb);
      drive(r_rw, r_mr, r_mw, r_pc, r_wa, r_alu, r_sb);
      acc = 1'b0;
      for (int t = 0; t < 300 && !acc; t++) begin
        @(negedge clk);
        #1;
        acc = !stallM;
        tick();
      end
      chk("rnd_accept", 64'(acc), 1);
      if ($urandom_range(0, 3) == 0) begin
        clear_in();
        tick();
      end
    end
    clear_in();
    for (int t = 0; t < 500 && (xq.size() != 0 || wq.size() != 0); t++) tick();
    repeat (5) tick();
    chk("rnd_xfer_drained", 64'(xq.size()), 0);
    chk("rnd_wb_drained", 64'(wq.size()), 0);
    mon_en = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
